// File: rtl/square_f32.sv
// Multi-cycle binary32 squarer: shift-add 24x24 mantissa product, truncating.
// Denormal operands and underflowing results are flushed to zero.
module square_f32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic [WIDTH-1:0] a,
    output logic             rdy,
    output logic [WIDTH-1:0] sq
);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        NORM,
        DONE
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    state_t state, state_n;

    logic [47:0] acc;
    logic [47:0] mcand;
    logic [23:0] mplier;
    logic [4:0]  cnt;
    logic [9:0]  exp_q;
    logic        sgn_q;
    logic [31:0] res;

    logic [7:0]  a_ea;
    logic        a_zero;
    logic        a_nan;
    logic        a_inf;
    logic        a_special;
    logic [31:0] spec_res;
    logic        a_sgn;

    logic        n;
    logic [22:0] frac;
    logic [9:0]  e_n;
    logic [31:0] packed_res;

    assign a_ea      = a[30:23];
    assign a_zero    = (a_ea == 8'd0);
    assign a_nan     = (&a_ea) && (|a[22:0]);
    assign a_inf     = (&a_ea) && !(|a[22:0]);
    assign a_special = a_zero | (&a_ea);

    // Sign of a*a is s^s, i.e. always positive.
    assign a_sgn = a[31] ^ a[31];

    always_comb begin
        spec_res = 32'h0;
        unique case (1'b1)
            a_nan:   spec_res = QNAN;
            a_inf:   spec_res = PINF;
            default: spec_res = 32'h0;
        endcase
    end

    assign n    = acc[47];
    assign frac = n ? acc[46:24] : acc[45:23];
    assign e_n  = exp_q + {9'd0, n};

    always_comb begin
        packed_res = {sgn_q, e_n[7:0], frac};
        if ($signed(e_n) >= $signed(10'd255)) begin
            packed_res = PINF;
        end else if ($signed(e_n) <= $signed(10'd0)) begin
            packed_res = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (EN) begin
                    state_n = a_special ? DONE : MULT;
                end
            end
            MULT: begin
                if (!EN) begin
                    state_n = IDLE;
                end else if (cnt == 5'd23) begin
                    state_n = NORM;
                end
            end
            NORM: begin
                state_n = EN ? DONE : IDLE;
            end
            DONE: begin
                if (!EN) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            exp_q  <= '0;
            sgn_q  <= 1'b0;
            res    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (EN) begin
                        acc    <= '0;
                        mcand  <= {24'd0, 1'b1, a[22:0]};
                        mplier <= {1'b1, a[22:0]};
                        cnt    <= '0;
                        exp_q  <= {1'b0, a_ea, 1'b0} - 10'd127;
                        sgn_q  <= a_sgn;
                        res    <= spec_res;
                    end
                end
                MULT: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                end
                NORM: begin
                    res <= packed_res;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs trail DONE by one edge but drop with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy <= 1'b0;
            sq  <= '0;
        end else if (state == DONE && EN) begin
            rdy <= 1'b1;
            sq  <= res;
        end else begin
            rdy <= 1'b0;
            sq  <= '0;
        end
    end

endmodule

// File: tb/tb_square_f32.sv
// Directed bench for square_f32: latency, arithmetic, specials,
// boundaries, abort and reset behaviour.
module tb_square_f32;

    logic        clk = 1'b0;
    logic        rst;
    logic        EN;
    logic [31:0] a;
    logic        rdy;
    logic [31:0] sq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    square_f32 #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .EN (EN),
        .a  (a),
        .rdy(rdy),
        .sq (sq)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    task automatic start(input logic [31:0] v);
        @(negedge clk);
        a  = v;
        EN = 1'b1;
        @(posedge clk);
    endtask

    task automatic wait_rdy(output int lat, output int leak);
        lat  = 0;
        leak = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                lat = i;
                break;
            end
            if (sq != 32'h0) leak++;
        end
    endtask

    task automatic quiet(input int cycles, output int bad);
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy || sq != 32'h0) bad++;
        end
    endtask

    task automatic run_op(input string tag,
                          input logic [31:0] v,
                          input logic [31:0] exp,
                          input int exp_lat);
        int lat;
        int leak;
        start(v);
        wait_rdy(lat, leak);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_sq"}, sq, exp);
        check({tag, "_leak"}, leak, 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold"}, {31'd0, rdy}, 32'd1);
        EN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rel_rdy"}, {31'd0, rdy}, 32'd0);
        check({tag, "_rel_sq"}, sq, 32'h0);
    endtask

    initial begin
        int bad;
        int lat;
        int leak;

        rst = 1'b1;
        EN  = 1'b0;
        a   = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", {31'd0, rdy}, 32'd0);
        check("rst_sq", sq, 32'h0);
        rst = 1'b0;

        run_op("three",  32'h4040_0000, 32'h4110_0000, 26);
        run_op("neg2",   32'hC000_0000, 32'h4080_0000, 26);
        run_op("onehalf",32'h3FC0_0000, 32'h4010_0000, 26);
        run_op("trunc",  32'h3F80_0001, 32'h3F80_0002, 26);
        run_op("ovf",    32'h6000_0000, 32'h7F80_0000, 26);
        run_op("unf",    32'h1F80_0000, 32'h0000_0000, 26);
        run_op("denorm", 32'h0000_0001, 32'h0000_0000, 1);
        run_op("nan",    32'h7FC0_0001, 32'h7FC0_0000, 1);
        run_op("ninf",   32'hFF80_0000, 32'h7F80_0000, 1);
        run_op("nzero",  32'h8000_0000, 32'h0000_0000, 1);

        // Abort partway through MULT.
        start(32'h4040_0000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        EN = 1'b0;
        quiet(30, bad);
        check("abort_quiet", bad, 0);
        run_op("after_abort", 32'h4040_0000, 32'h4110_0000, 26);

        // Reset during MULT with EN still high.
        start(32'h4040_0000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mult_rdy", {31'd0, rdy}, 32'd0);
        check("rst_mult_sq", sq, 32'h0);
        rst = 1'b0;
        EN  = 1'b0;
        quiet(30, bad);
        check("rst_mult_quiet", bad, 0);

        // Reset while in DONE.
        start(32'h3FC0_0000);
        wait_rdy(lat, leak);
        check("pre_rst_done_lat", lat, 26);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_done_rdy", {31'd0, rdy}, 32'd0);
        check("rst_done_sq", sq, 32'h0);
        rst = 1'b0;
        EN  = 1'b0;
        @(posedge clk);

        // rst wins over EN in IDLE.
        @(negedge clk);
        a   = 32'h7F80_0000;
        EN  = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        EN  = 1'b0;
        quiet(30, bad);
        check("rst_en_nostart", bad, 0);

        run_op("final", 32'h4040_0000, 32'h4110_0000, 26);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
